// File: rtl/alu_cmd_issuer.sv
// Command FIFO + issue engine for a 4-bit external ALU, with a local accumulator as operand A.
// Optional feature macro: ALU_CMD_ISSUER_ZERO_FLAG_EN adds the rsp_zero output.
`timescale 1ns/1ps
module alu_cmd_issuer #(
    parameter int unsigned DATA_W     = 4,
    parameter int unsigned SEL_W      = 3,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [SEL_W-1:0]  cmd_sel,
    input  logic [DATA_W-1:0] cmd_operand,
    input  logic              cmd_load,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [SEL_W-1:0]  alu_sel,
    input  logic [DATA_W-1:0] alu_y,
    input  logic              alu_carry,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_carry,
    output logic [DATA_W-1:0] acc,
`ifdef ALU_CMD_ISSUER_ZERO_FLAG_EN
    output logic              busy,
    output logic              rsp_zero
`else
    output logic              busy
`endif
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic              load;
        logic [SEL_W-1:0]  sel;
        logic [DATA_W-1:0] operand;
    } cmd_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    cmd_t              mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    state_t            state_q;
    cmd_t              op_q;
    logic [DATA_W-1:0] acc_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic              rsp_valid_q;
    logic              rsp_carry_q;
`ifdef ALU_CMD_ISSUER_ZERO_FLAG_EN
    logic              rsp_zero_q;
`endif

    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] result_d;
    logic              result_carry_d;

    assign full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty = (count_q == '0);
    assign push  = cmd_valid && !full;
    assign pop   = (state_q == S_IDLE) && !empty;

    // Only ADD/SUB carry is meaningful; loads bypass the ALU entirely
    always_comb begin
        result_d       = alu_y;
        result_carry_d = 1'b0;
        if (op_q.load) begin
            result_d = op_q.operand;
        end else if ((op_q.sel == SEL_W'(0)) || (op_q.sel == SEL_W'(1))) begin
            result_carry_d = alu_carry;
        end
    end

    always_comb begin
        alu_a   = acc_q;
        alu_b   = '0;
        alu_sel = '0;
        if (state_q == S_ISSUE) begin
            alu_b   = op_q.operand;
            alu_sel = op_q.sel;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {cmd_load, cmd_sel, cmd_operand};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            state_q     <= S_IDLE;
            op_q        <= '0;
            acc_q       <= '0;
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_carry_q <= 1'b0;
`ifdef ALU_CMD_ISSUER_ZERO_FLAG_EN
            rsp_zero_q  <= 1'b0;
`endif
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);

            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        op_q    <= mem_q[rd_ptr_q];
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    acc_q       <= result_d;
                    rsp_data_q  <= result_d;
                    rsp_carry_q <= result_carry_d;
                    rsp_valid_q <= 1'b1;
`ifdef ALU_CMD_ISSUER_ZERO_FLAG_EN
                    rsp_zero_q  <= (result_d == '0);
`endif
                    state_q     <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = !full;
    assign busy      = (state_q != S_IDLE) || !empty;
    assign acc       = acc_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_carry = rsp_carry_q;
`ifdef ALU_CMD_ISSUER_ZERO_FLAG_EN
    assign rsp_zero  = rsp_zero_q;
`endif

endmodule
